// File: rtl/thermal_pkg.sv
// Shared types and constants for the room thermal model: mode encoding,
// Q8.8 temperature format, and decoding of the controller command.
package thermal_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_HEAT  = 2'd1,
    MODE_COOL  = 2'd2,
    MODE_FAULT = 2'd3
  } mode_t;

  localparam int TEMP_W    = 16;
  localparam int FRAC_BITS = 8;

  // Only a clean one-hot command selects a working mode; anything else is a fault.
  function automatic mode_t decode_cmd(input logic heat, input logic cool, input logic idle);
    mode_t m;
    case ({heat, cool, idle})
      3'b100:  m = MODE_HEAT;
      3'b010:  m = MODE_COOL;
      3'b001:  m = MODE_IDLE;
      default: m = MODE_FAULT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..DIV-1 and pulses tick for one cycle
// while the count sits at DIV-1, then wraps to 0.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/room_thermal_model.sv
// Room temperature model: a tick-driven mode FSM that nudges a saturating
// Q8.8 temperature toward heat/cool/ambient drift, with a preset load path.
module room_thermal_model
  import thermal_pkg::*;
#(
  parameter int                        TICK_DIV     = 10,
  parameter logic signed [TEMP_W-1:0]  INIT_TEMP    = 16'sd5120,
  parameter logic signed [TEMP_W-1:0]  AMBIENT_STEP = 16'sd26,
  parameter logic signed [TEMP_W-1:0]  COND_STEP    = 16'sd128,
  parameter logic signed [TEMP_W-1:0]  TEMP_MIN     = -16'sd2560,
  parameter logic signed [TEMP_W-1:0]  TEMP_MAX     = 16'sd12800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              heat,
  input  logic              cool,
  input  logic              idle,
  input  logic              load,
  input  logic [TEMP_W-1:0] load_temp,
  output logic [TEMP_W-1:0] temp,
  output logic              temp_valid,
  output logic [1:0]        mode,
  output logic              fault,
  output logic              at_limit
);

  function automatic logic signed [TEMP_W:0] sx(input logic [TEMP_W-1:0] v);
    return {v[TEMP_W-1], v};
  endfunction

  // Saturate a widened result back into the legal temperature range.
  function automatic logic signed [TEMP_W-1:0] clamp(input logic signed [TEMP_W:0] v);
    logic signed [TEMP_W-1:0] r;
    if (v < sx(TEMP_MIN))      r = TEMP_MIN;
    else if (v > sx(TEMP_MAX)) r = TEMP_MAX;
    else                       r = v[TEMP_W-1:0];
    return r;
  endfunction

  localparam logic signed [TEMP_W:0] NET_STEP = sx(COND_STEP) - sx(AMBIENT_STEP);

  logic                     tick;
  mode_t                    cmd_mode;
  mode_t                    mode_q, mode_next;
  logic signed [TEMP_W-1:0] temp_q, temp_next;
  logic signed [TEMP_W:0]   sum;
  logic                     valid_q, valid_next;
  logic                     fault_q, at_limit_q;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign cmd_mode = decode_cmd(heat, cool, idle);

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    mode_next  = mode_q;
    temp_next  = temp_q;
    valid_next = 1'b0;
    sum        = sx(temp_q);
    if (load) begin
      temp_next  = clamp(sx(load_temp));
      valid_next = 1'b1;
    end else if (tick) begin
      mode_next = cmd_mode;
      // Entering, staying in, or leaving FAULT only moves the mode.
      if (cmd_mode != MODE_FAULT && mode_q != MODE_FAULT) begin
        case (cmd_mode)
          MODE_HEAT: sum = sx(temp_q) + NET_STEP;
          MODE_COOL: sum = sx(temp_q) - NET_STEP;
          default:   sum = sx(temp_q) + sx(AMBIENT_STEP);
        endcase
        temp_next  = clamp(sum);
        valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      temp_q     <= INIT_TEMP;
      mode_q     <= MODE_IDLE;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      temp_q     <= temp_next;
      mode_q     <= mode_next;
      valid_q    <= valid_next;
      fault_q    <= (mode_next == MODE_FAULT);
      at_limit_q <= (temp_next == TEMP_MIN) || (temp_next == TEMP_MAX);
    end
  end

  assign temp       = temp_q;
  assign mode       = mode_q;
  assign temp_valid = valid_q;
  assign fault      = fault_q;
  assign at_limit   = at_limit_q;

endmodule
